alu_issue_stage: RTL and testbench

Registered ALU issue stage sitting between instruction decode and the 32-bit ALU. It decodes a fetched MIPS instruction plus its register-file operands into the ALU's 4-bit operation code and its two 32-bit operands. It delivers them through a two-entry skid buffer with valid/ready handshakes on both sides. Its outputs drive the ALU's `ALUControl`, `A` and `B` inputs directly.

---
 rtl/alu_issue_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS instruction and its register operands into
// ALU control/operands, delivered through a two-entry skid buffer with
// valid/ready handshakes on both sides.
// Optional feature macro: ALU_ISSUE_MUL_EN (enables SPECIAL2 mul -> MUL).
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Instr,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [3:0]        ALUControl,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              Illegal
);

  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned REG_W   = 5;

  // ALU operation codes
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_BGEZ = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_BGTZ = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_BLEZ = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_BLTZ = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1001;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b1010;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b1011;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1111;

  // Primary opcodes
  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'h01;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'h06;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'h07;
  localparam logic [OP_W-1:0] OP_ADDI    = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI    = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI    = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI     = 6'h0D;
  localparam logic [OP_W-1:0] OP_XORI    = 6'h0E;
  localparam logic [OP_W-1:0] OP_LB      = 6'h20;
  localparam logic [OP_W-1:0] OP_LH      = 6'h21;
  localparam logic [OP_W-1:0] OP_LW      = 6'h23;
  localparam logic [OP_W-1:0] OP_SB      = 6'h28;
  localparam logic [OP_W-1:0] OP_SH      = 6'h29;
  localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [OP_W-1:0] FN_SLL = 6'h00;
  localparam logic [OP_W-1:0] FN_SRL = 6'h02;
  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_XOR = 6'h26;
  localparam logic [OP_W-1:0] FN_NOR = 6'h27;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  // REGIMM rt selectors
  localparam logic [REG_W-1:0] RT_BLTZ = 5'd0;
  localparam logic [REG_W-1:0] RT_BGEZ = 5'd1;

`ifdef ALU_ISSUE_MUL_EN
  localparam logic [CTRL_W-1:0] ALU_MUL     = 4'b0010;
  localparam logic [OP_W-1:0]   OP_SPECIAL2 = 6'h1C;
  localparam logic [OP_W-1:0]   FN_MUL      = 6'h02;
`endif

  // One decoded ALU operation as held in either buffer entry
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  entry_t dec;
  entry_t out_q;
  entry_t skid_q;

  logic accept;
  logic consume;
  logic load_out;
  logic load_skid;
  logic promote;

  logic [OP_W-1:0]   opcode;
  logic [OP_W-1:0]   funct;
  logic [REG_W-1:0]  rt_field;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] shamt_ext;
  logic              unused_rs_field;

  assign opcode    = Instr[31:26];
  assign funct     = Instr[5:0];
  assign rt_field  = Instr[20:16];
  assign imm       = Instr[15:0];
  assign imm_sext  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext  = DATA_W'(imm);
  assign shamt_ext = DATA_W'(Instr[10:6]);

  // The rs register number is not needed: its value arrives on RsData.
  assign unused_rs_field = &{1'b0, Instr[25:21]};

  // Build a legal decoded entry.
  function automatic entry_t mk(input logic [CTRL_W-1:0] ctrl,
                                input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b);
    entry_t e;
    e.ctrl    = ctrl;
    e.a       = a;
    e.b       = b;
    e.illegal = 1'b0;
    return e;
  endfunction

  // Instruction decode: opcode/funct to ALU code and operand selection
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD:         dec = mk(ALU_ADD, RsData, RtData);
          FN_SUB, FN_SLT: dec = mk(ALU_SUB, RsData, RtData);
          FN_AND:         dec = mk(ALU_AND, RsData, RtData);
          FN_OR:          dec = mk(ALU_OR,  RsData, RtData);
          FN_NOR:         dec = mk(ALU_NOR, RsData, RtData);
          FN_XOR:         dec = mk(ALU_XOR, RsData, RtData);
          FN_SLL:         dec = mk(ALU_SLL, RtData, shamt_ext);
          FN_SRL:         dec = mk(ALU_SRL, RtData, shamt_ext);
          default:        ;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_LB, OP_LH, OP_SB, OP_SH:
                 dec = mk(ALU_ADD, RsData, imm_sext);
      OP_SLTI:   dec = mk(ALU_SUB, RsData, imm_sext);
      OP_ANDI:   dec = mk(ALU_AND, RsData, imm_zext);
      OP_ORI:    dec = mk(ALU_OR,  RsData, imm_zext);
      OP_XORI:   dec = mk(ALU_XOR, RsData, imm_zext);
      OP_BEQ, OP_BNE:
                 dec = mk(ALU_SUB, RsData, RtData);
      OP_BGTZ:   dec = mk(ALU_BGTZ, RsData, '0);
      OP_BLEZ:   dec = mk(ALU_BLEZ, RsData, '0);
      OP_REGIMM: begin
        if (rt_field == RT_BGEZ) begin
          dec = mk(ALU_BGEZ, RsData, '0);
        end else if (rt_field == RT_BLTZ) begin
          dec = mk(ALU_BLTZ, RsData, '0);
        end
      end
`ifdef ALU_ISSUE_MUL_EN
      OP_SPECIAL2: begin
        if (funct == FN_MUL) begin
          dec = mk(ALU_MUL, RsData, RtData);
        end
      end
`endif
      default: ;
    endcase
  end

  assign accept  = InValid & InReady;
  assign consume = OutValid & OutReady;

  // Skid buffer next state and entry load controls; flush overrides all
  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    promote    = 1'b0;
    if (Flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            load_out   = 1'b1;
          end
        end
        ONE: begin
          case ({accept, consume})
            2'b10: begin
              state_next = FULL;
              load_skid  = 1'b1;
            end
            2'b01: state_next = EMPTY;
            2'b11: load_out = 1'b1;
            default: ;
          endcase
        end
        FULL: begin
          if (consume) begin
            state_next = ONE;
            promote    = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Registered handshake flags derived from the next state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      InReady  <= 1'b0;
      OutValid <= 1'b0;
    end else begin
      InReady  <= (state_next != FULL);
      OutValid <= (state_next != EMPTY);
    end
  end

  // Output and skid entries; the output holds unless reloaded or promoted
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) begin
        out_q <= dec;
      end else if (promote) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign ALUControl = out_q.ctrl;
  assign A          = out_q.a;
  assign B          = out_q.b;
  assign Illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model plus
// directed vectors with hand-computed expectations.
module tb_alu_issue_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic        Illegal;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.DATA_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .Instr(Instr), .RsData(RsData), .RtData(RtData),
    .OutValid(OutValid), .OutReady(OutReady),
    .ALUControl(ALUControl), .A(A), .B(B), .Illegal(Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Reference decode written straight from the instruction table
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt);
    exp_t e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] sx;
    logic [31:0] zx;
    logic [31:0] sh;
    op = ins[31:26];
    fn = ins[5:0];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    sh = {27'd0, ins[10:6]};
    e  = '{code: 4'h0, a: 32'h0, b: 32'h0, ill: 1'b1};
    if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h27, 6'h26}) begin
      e = '{code: 4'h0, a: rs, b: rt, ill: 1'b0};
      case (fn)
        6'h22, 6'h2A: e.code = 4'b0001;
        6'h24:        e.code = 4'b0111;
        6'h25:        e.code = 4'b1000;
        6'h27:        e.code = 4'b1001;
        6'h26:        e.code = 4'b1010;
        default:      e.code = 4'b0000;
      endcase
    end else if (op == 6'h00 && fn == 6'h00) begin
      e = '{code: 4'b1011, a: rt, b: sh, ill: 1'b0};
    end else if (op == 6'h00 && fn == 6'h02) begin
      e = '{code: 4'b1111, a: rt, b: sh, ill: 1'b0};
    end else if (op inside {6'h08, 6'h23, 6'h2B, 6'h20, 6'h21, 6'h28, 6'h29}) begin
      e = '{code: 4'b0000, a: rs, b: sx, ill: 1'b0};
    end else if (op == 6'h0A) begin
      e = '{code: 4'b0001, a: rs, b: sx, ill: 1'b0};
    end else if (op == 6'h0C) begin
      e = '{code: 4'b0111, a: rs, b: zx, ill: 1'b0};
    end else if (op == 6'h0D) begin
      e = '{code: 4'b1000, a: rs, b: zx, ill: 1'b0};
    end else if (op == 6'h0E) begin
      e = '{code: 4'b1010, a: rs, b: zx, ill: 1'b0};
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '{code: 4'b0001, a: rs, b: rt, ill: 1'b0};
    end else if (op == 6'h07) begin
      e = '{code: 4'b0100, a: rs, b: 32'h0, ill: 1'b0};
    end else if (op == 6'h06) begin
      e = '{code: 4'b0101, a: rs, b: 32'h0, ill: 1'b0};
    end else if (op == 6'h01 && ins[20:16] == 5'd1) begin
      e = '{code: 4'b0011, a: rs, b: 32'h0, ill: 1'b0};
    end else if (op == 6'h01 && ins[20:16] == 5'd0) begin
      e = '{code: 4'b0110, a: rs, b: 32'h0, ill: 1'b0};
`ifdef ALU_ISSUE_MUL_EN
    end else if (op == 6'h1C && fn == 6'h02) begin
      e = '{code: 4'b0010, a: rs, b: rt, ill: 1'b0};
`endif
    end
    return e;
  endfunction

  // Model state: ordered list of held operations
  exp_t q[$];
  bit   m_rdy  = 1'b0;
  bit   m_zero = 1'b1;
  bit   m_acc;
  bit   m_con;
  exp_t cur;

  // Model update on each rising edge
  always @(posedge Clk) begin
    if (!Reset) begin
      q.delete();
      m_rdy  = 1'b0;
      m_zero = 1'b1;
    end else if (Flush) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      m_acc = InValid && m_rdy;
      m_con = (q.size() > 0) && OutReady;
      if (m_con) void'(q.pop_front());
      if (m_acc) begin
        q.push_back(ref_decode(Instr, RsData, RtData));
        m_zero = 1'b0;
      end
      m_rdy = (q.size() < 2);
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(negedge Clk) begin
    check("cmp_outvalid", 32'(OutValid), 32'(q.size() > 0));
    check("cmp_inready", 32'(InReady), 32'(m_rdy));
    if (q.size() > 0) begin
      cur = q[0];
      check("cmp_ctrl", 32'(ALUControl), 32'(cur.code));
      check("cmp_a", A, cur.a);
      check("cmp_b", B, cur.b);
      check("cmp_illegal", 32'(Illegal), 32'(cur.ill));
    end else if (m_zero) begin
      check("cmp_ctrl_zero", 32'(ALUControl), 32'h0);
      check("cmp_a_zero", A, 32'h0);
      check("cmp_b_zero", B, 32'h0);
      check("cmp_ill_zero", 32'(Illegal), 32'h0);
    end
  end

  // Present one instruction until accepted (called at a falling edge)
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bit rdy;
    bit done;
    done    = 1'b0;
    InValid = 1'b1;
    Instr   = ins;
    RsData  = rs;
    RtData  = rt;
    for (int k = 0; k < 20 && !done; k++) begin
      rdy = InReady;
      @(negedge Clk);
      if (rdy) done = 1'b1;
    end
    InValid = 1'b0;
    if (!done) check("send_timeout", 32'h0, 32'h1);
  endtask

  // Issue with OutReady high and check the presented operation literally
  task automatic issue_check(input string name, input logic [31:0] ins,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] code, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ill);
    send(ins, rs, rt);
    check({name, "_valid"}, 32'(OutValid), 32'h1);
    check({name, "_ctrl"}, 32'(ALUControl), code);
    check({name, "_a"}, A, a);
    check({name, "_b"}, B, b);
    check({name, "_ill"}, 32'(Illegal), ill);
  endtask

  task automatic drain();
    InValid  = 1'b0;
    OutReady = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  logic [31:0] vec[26];

  initial begin
    Reset = 1'b0; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    Instr = 32'h0; RsData = 32'h0; RtData = 32'h0;

    // Reset held for three edges, then released
    repeat (3) @(negedge Clk);
    check("rst_outvalid", 32'(OutValid), 32'h0);
    check("rst_inready", 32'(InReady), 32'h0);
    check("rst_ctrl", 32'(ALUControl), 32'h0);
    check("rst_ab", A | B, 32'h0);
    check("rst_illegal", 32'(Illegal), 32'h0);
    Reset = 1'b1;
    check("rel_inready_low", 32'(InReady), 32'h0);
    @(negedge Clk);
    check("rel_inready_high", 32'(InReady), 32'h1);

    // Directed decode cases with OutReady held high
    OutReady = 1'b1;
    issue_check("add", r_ins(1, 2, 3, 0, 6'h20), 32'd5, 32'd7, 32'h0, 32'd5, 32'd7, 32'h0);
    issue_check("addi", i_ins(6'h08, 1, 2, 16'hFFFC), 32'd10, 32'd3, 32'h0, 32'd10, 32'hFFFFFFFC, 32'h0);
    issue_check("andi", i_ins(6'h0C, 1, 2, 16'hFFFC), 32'd10, 32'd3, 32'h7, 32'd10, 32'h0000FFFC, 32'h0);
    issue_check("sll", r_ins(0, 2, 3, 4, 6'h00), 32'h55, 32'd1, 32'hB, 32'd1, 32'd4, 32'h0);
    issue_check("bltz", i_ins(6'h01, 1, 0, 16'h0010), 32'h80000000, 32'h9, 32'h6, 32'h80000000, 32'h0, 32'h0);
    issue_check("srl", r_ins(0, 2, 3, 31, 6'h02), 32'h1, 32'hF0000000, 32'hF, 32'hF0000000, 32'd31, 32'h0);
    issue_check("nop", 32'h0, 32'h12, 32'h34, 32'hB, 32'h34, 32'h0, 32'h0);
    issue_check("slt", r_ins(1, 2, 3, 0, 6'h2A), 32'd3, 32'd9, 32'h1, 32'd3, 32'd9, 32'h0);
    issue_check("bgez", i_ins(6'h01, 1, 1, 16'h0004), 32'd8, 32'd2, 32'h3, 32'd8, 32'h0, 32'h0);
    issue_check("regimm_bad", i_ins(6'h01, 1, 2, 16'h0004), 32'd8, 32'd2, 32'h0, 32'h0, 32'h0, 32'h1);
    issue_check("op3f", 32'hFC000000, 32'd8, 32'd2, 32'h0, 32'h0, 32'h0, 32'h1);
`ifdef ALU_ISSUE_MUL_EN
    issue_check("mul", {6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02}, 32'd6, 32'd7, 32'h2, 32'd6, 32'd7, 32'h0);
`else
    issue_check("mul", {6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02}, 32'd6, 32'd7, 32'h0, 32'h0, 32'h0, 32'h1);
`endif
    drain();

    // Backpressure: three instructions against a stalled consumer
    OutReady = 1'b0;
    send(i_ins(6'h08, 1, 2, 16'h0001), 32'h100, 32'h0);
    check("bp_rdy_one", 32'(InReady), 32'h1);
    send(i_ins(6'h08, 1, 2, 16'h0001), 32'h200, 32'h0);
    check("bp_rdy_full", 32'(InReady), 32'h0);
    InValid = 1'b1; Instr = i_ins(6'h08, 1, 2, 16'h0001); RsData = 32'h300;
    @(negedge Clk);
    check("bp_hold_rdy", 32'(InReady), 32'h0);
    check("bp_hold_a", A, 32'h100);
    OutReady = 1'b1;
    @(negedge Clk);
    check("bp_issue2_a", A, 32'h200);
    check("bp_issue2_rdy", 32'(InReady), 32'h1);
    @(negedge Clk);
    check("bp_issue3_a", A, 32'h300);
    InValid = 1'b0;
    @(negedge Clk);
    check("bp_empty", 32'(OutValid), 32'h0);

    // Flush while full with a new instruction offered
    OutReady = 1'b0;
    send(i_ins(6'h08, 1, 2, 16'h0001), 32'h400, 32'h0);
    send(i_ins(6'h08, 1, 2, 16'h0001), 32'h500, 32'h0);
    InValid = 1'b1; Instr = r_ins(1, 2, 3, 0, 6'h20); RsData = 32'h600;
    Flush = 1'b1;
    @(negedge Clk);
    Flush = 1'b0; InValid = 1'b0;
    check("fl_outvalid", 32'(OutValid), 32'h0);
    check("fl_inready", 32'(InReady), 32'h1);
    OutReady = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      check("fl_no_issue", 32'(OutValid), 32'h0);
    end

    // Reset while full discards both entries
    OutReady = 1'b0;
    send(i_ins(6'h0D, 1, 2, 16'h00F0), 32'h700, 32'h0);
    send(i_ins(6'h0D, 1, 2, 16'h00F0), 32'h800, 32'h0);
    Reset = 1'b0;
    @(negedge Clk);
    check("mrst_outvalid", 32'(OutValid), 32'h0);
    check("mrst_a", A, 32'h0);
    Reset = 1'b1;
    @(negedge Clk);
    check("mrst_inready", 32'(InReady), 32'h1);
    OutReady = 1'b1;
    issue_check("post_rst_xori", i_ins(6'h0E, 1, 2, 16'h8001), 32'hA, 32'h0, 32'hA, 32'hA, 32'h00008001, 32'h0);

    // Table sweep under intermittent backpressure, checked by the model
    vec = '{r_ins(1, 2, 3, 0, 6'h22), r_ins(1, 2, 3, 0, 6'h2A), r_ins(1, 2, 3, 0, 6'h24),
            r_ins(1, 2, 3, 0, 6'h25), r_ins(1, 2, 3, 0, 6'h27), r_ins(1, 2, 3, 0, 6'h26),
            r_ins(0, 2, 3, 7, 6'h02), r_ins(0, 2, 3, 9, 6'h00), 32'h0,
            i_ins(6'h0A, 1, 2, 16'h8000), i_ins(6'h23, 1, 2, 16'hFFF0), i_ins(6'h2B, 1, 2, 16'h0010),
            i_ins(6'h20, 1, 2, 16'h8001), i_ins(6'h21, 1, 2, 16'h7FFF), i_ins(6'h28, 1, 2, 16'hFFFF),
            i_ins(6'h29, 1, 2, 16'h0002), i_ins(6'h0D, 1, 2, 16'h8000), i_ins(6'h0E, 1, 2, 16'hFFFF),
            i_ins(6'h04, 1, 2, 16'h0003), i_ins(6'h05, 1, 2, 16'h0003), i_ins(6'h07, 1, 0, 16'h0003),
            i_ins(6'h06, 1, 0, 16'h0003), i_ins(6'h01, 1, 1, 16'h0003), i_ins(6'h01, 1, 3, 16'h0003),
            r_ins(1, 2, 3, 0, 6'h03), {6'h1C, 5'd1, 5'd2, 5'd3, 5'd0, 6'h02}};
    for (int i = 0; i < 26; i++) begin
      OutReady = (i % 3) != 0;
      send(vec[i], $urandom, $urandom);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
